// File: rtl/eject_sink_if.sv
// Eject-side bus for eject_sink: the router write handshake and the host read port.
// The master is the router/host side that drives requests; the slave is the sink.
interface eject_sink_if;
  logic        write_req_j;
  logic [63:0] eject;
  logic        w_j_ack;
  logic        rd_en;
  logic        rd_valid;
  logic [63:0] rd_data;

  modport master (
    output write_req_j, eject, rd_en,
    input  w_j_ack, rd_valid, rd_data
  );

  modport slave (
    input  write_req_j, eject, rd_en,
    output w_j_ack, rd_valid, rd_data
  );
endinterface

// File: rtl/eject_sink.sv
// Router eject-port consumer: acks single-flit packets, checks the destination,
// measures network latency and queues good flits in a show-ahead FIFO for the host.
module eject_sink #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      X_cur,
  input  logic [2:0]      Y_cur,
  input  logic            end_sim,
  eject_sink_if.slave     bus,
  output logic [31:0]     pkt_count,
  output logic [15:0]     err_count,
  output logic [31:0]     lat_sum,
  output logic [TS_W-1:0] lat_max
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     flit_q, flit_d;
  logic [TS_W-1:0] lat_q, lat_d;
  logic [TS_W-1:0] cyc_q;
  logic            ack_q, ack_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]     pkt_q, pkt_d;
  logic [15:0]     err_q, err_d;
  logic [31:0]     lat_sum_q, lat_sum_d;
  logic [TS_W-1:0] lat_max_q, lat_max_d;
  logic [63:0]     mem [DEPTH];

  logic            full_s, not_empty_s, dest_ok_s;
  logic            push_s, pop_s, misroute_s;
  logic [32:0]     sum_s;

  assign full_s      = (count_q == CNT_W'(DEPTH));
  assign not_empty_s = (count_q != CNT_W'(0));
  assign dest_ok_s   = (flit_q[63:61] == X_cur) && (flit_q[60:58] == Y_cur);
  assign pop_s       = bus.rd_en && not_empty_s;
  assign sum_s       = {1'b0, lat_sum_q} + {{(33-TS_W){1'b0}}, lat_q};

  // Handshake FSM: capture in IDLE, one-cycle ack and push/drop in ACK, settle in GAP.
  always_comb begin
    state_d    = state_q;
    flit_d     = flit_q;
    lat_d      = lat_q;
    ack_d      = 1'b0;
    push_s     = 1'b0;
    misroute_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.write_req_j && !full_s) begin
          flit_d  = bus.eject;
          lat_d   = cyc_q - bus.eject[51 -: TS_W];
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (dest_ok_s) begin
          push_s = 1'b1;
        end else begin
          misroute_s = 1'b1;
        end
        state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Statistics: frozen while end_sim is high; sums and error count saturate.
  always_comb begin
    pkt_d     = pkt_q;
    err_d     = err_q;
    lat_sum_d = lat_sum_q;
    lat_max_d = lat_max_q;
    if (push_s && !end_sim) begin
      pkt_d     = pkt_q + 32'd1;
      lat_sum_d = sum_s[32] ? 32'hFFFF_FFFF : sum_s[31:0];
      lat_max_d = (lat_q > lat_max_q) ? lat_q : lat_max_q;
    end else begin
      pkt_d = pkt_q;
    end
    if (misroute_s && !end_sim && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end else begin
      err_d = err_q;
    end
  end

  // FIFO pointer and occupancy next-state; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // State, counters and FIFO control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      flit_q    <= 64'd0;
      lat_q     <= '0;
      cyc_q     <= '0;
      ack_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_q     <= 32'd0;
      err_q     <= 16'd0;
      lat_sum_q <= 32'd0;
      lat_max_q <= '0;
    end else begin
      state_q   <= state_d;
      flit_q    <= flit_d;
      lat_q     <= lat_d;
      cyc_q     <= cyc_q + TS_W'(1);
      ack_q     <= ack_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_q     <= pkt_d;
      err_q     <= err_d;
      lat_sum_q <= lat_sum_d;
      lat_max_q <= lat_max_d;
    end
  end

  // FIFO storage; contents need no reset because emptiness is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_q] <= flit_q;
    end
  end

  assign bus.w_j_ack  = ack_q;
  assign bus.rd_valid = not_empty_s;
  assign bus.rd_data  = not_empty_s ? mem[rd_ptr_q] : 64'd0;
  assign pkt_count    = pkt_q;
  assign err_count    = err_q;
  assign lat_sum      = lat_sum_q;
  assign lat_max      = lat_max_q;
endmodule

// File: tb/tb_eject_sink.sv
// Directed bench for eject_sink: a flit scoreboard feeds expected host reads and a
// small statistics model tracks expected counter values.
module tb_eject_sink;
  localparam int TS_W  = 20;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      X_cur, Y_cur;
  logic            end_sim;
  logic [31:0]     pkt_count, lat_sum;
  logic [15:0]     err_count;
  logic [TS_W-1:0] lat_max;

  eject_sink_if bus();

  eject_sink #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(rst_n), .X_cur(X_cur), .Y_cur(Y_cur), .end_sim(end_sim),
    .bus(bus), .pkt_count(pkt_count), .err_count(err_count),
    .lat_sum(lat_sum), .lat_max(lat_max)
  );

  always #5 clk = ~clk;

  // Reference cycle counter, used to build timestamps and expected latencies.
  logic [TS_W-1:0] tb_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 20'd1;
  end

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];
  logic [31:0] e_pkt, e_sum;
  logic [15:0] e_err;
  logic [TS_W-1:0] e_max;
  logic [63:0] cur_flit;
  bit got;
  int nw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [2:0] dx, input logic [2:0] dy,
                                     input logic [TS_W-1:0] ts, input logic [31:0] pl);
    return {dx, dy, 3'd5, 3'd1, ts, pl};
  endfunction

  task automatic drive_req(input logic [63:0] f);
    cur_flit = f;
    bus.eject = f;
    bus.write_req_j = 1'b1;
    if (f[63:58] == {3'd2, 3'd3}) sb.push_back(f);
  endtask

  task automatic wait_ack(input int budget, output bit ok, output int n);
    logic [TS_W-1:0] lat;
    logic [32:0] s;
    ok = 1'b0;
    n = 0;
    while (!ok && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (bus.w_j_ack === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      lat = tb_cyc - 20'd1 - cur_flit[51 -: TS_W];
      if (!end_sim) begin
        if (cur_flit[63:58] == {3'd2, 3'd3}) begin
          e_pkt = e_pkt + 32'd1;
          s = {1'b0, e_sum} + {13'd0, lat};
          e_sum = s[32] ? 32'hFFFF_FFFF : s[31:0];
          if (lat > e_max) e_max = lat;
        end else if (e_err != 16'hFFFF) begin
          e_err = e_err + 16'd1;
        end
      end
      bus.write_req_j = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
    end
  endtask

  task automatic pop_one(input string tag);
    logic [63:0] exp;
    chk({tag, "_rd_valid"}, {63'd0, bus.rd_valid}, 64'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    chk({tag, "_rd_data"}, bus.rd_data, exp);
    bus.rd_en = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_pkt"}, {32'd0, pkt_count}, {32'd0, e_pkt});
    chk({tag, "_err"}, {48'd0, err_count}, {48'd0, e_err});
    chk({tag, "_lat_sum"}, {32'd0, lat_sum}, {32'd0, e_sum});
    chk({tag, "_lat_max"}, {44'd0, lat_max}, {44'd0, e_max});
  endtask

  initial begin
    rst_n = 1'b0;
    bus.write_req_j = 1'b0;
    bus.eject = 64'd0;
    bus.rd_en = 1'b0;
    end_sim = 1'b0;
    X_cur = 3'd2;
    Y_cur = 3'd3;
    e_pkt = 32'd0; e_err = 16'd0; e_sum = 32'd0; e_max = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_ack", {63'd0, bus.w_j_ack}, 64'd0);
    chk("rst_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
    chk("rst_rd_data", bus.rd_data, 64'd0);
    check_stats("rst");

    // Good flit at cyc=100 with timestamp 90.
    for (int k = 0; k < 500 && tb_cyc != 20'd100; k++) begin @(posedge clk); #1; end
    drive_req(mk(3'd2, 3'd3, 20'd90, 32'hCAFE));
    wait_ack(8, got, nw);
    chk("t1_acked", {63'd0, got}, 64'd1);
    chk("t1_ack_delay", 64'(nw), 64'd1);
    chk("t1_lat_sum", {32'd0, lat_sum}, 64'd10);
    chk("t1_lat_max", {44'd0, lat_max}, 64'd10);
    check_stats("t1");
    pop_one("t1");
    chk("t1_empty", {63'd0, bus.rd_valid}, 64'd0);

    // Misrouted flit is acked but dropped.
    drive_req(mk(3'd1, 3'd3, tb_cyc - 20'd3, 32'hBEEF));
    wait_ack(8, got, nw);
    chk("t2_acked", {63'd0, got}, 64'd1);
    chk("t2_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
    chk("t2_err", {48'd0, err_count}, 64'd1);
    check_stats("t2");

    // Fill the FIFO, stall the fifth flit, then release it with one pop.
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(mk(3'd2, 3'd3, tb_cyc - 20'd5, 32'h100 + 32'(i)));
      wait_ack(8, got, nw);
      chk("t3_fill_acked", {63'd0, got}, 64'd1);
    end
    drive_req(mk(3'd2, 3'd3, tb_cyc - 20'd5, 32'h1FF));
    wait_ack(6, got, nw);
    chk("t3_stalled", {63'd0, got}, 64'd0);
    pop_one("t3_pop");
    wait_ack(2, got, nw);
    chk("t3_released", {63'd0, got}, 64'd1);
    check_stats("t3");
    for (int i = 0; i < DEPTH; i++) pop_one("t3_drain");
    chk("t3_empty", {63'd0, bus.rd_valid}, 64'd0);

    // end_sim freezes statistics while flits still land in the FIFO.
    end_sim = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_req(mk(3'd2, 3'd3, tb_cyc - 20'd7, 32'h200 + 32'(i)));
      wait_ack(8, got, nw);
      chk("t4_acked", {63'd0, got}, 64'd1);
    end
    chk("t4_rd_valid", {63'd0, bus.rd_valid}, 64'd1);
    check_stats("t4");
    end_sim = 1'b0;

    // Reset during the ACK cycle with two entries buffered.
    drive_req(mk(3'd2, 3'd3, tb_cyc, 32'h300));
    @(posedge clk); #1;
    chk("t5_ack_before", {63'd0, bus.w_j_ack}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_ack_drop", {63'd0, bus.w_j_ack}, 64'd0);
    chk("t5_rd_valid", {63'd0, bus.rd_valid}, 64'd0);
    bus.write_req_j = 1'b0;
    sb.delete();
    e_pkt = 32'd0; e_err = 16'd0; e_sum = 32'd0; e_max = '0;
    check_stats("t5");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Counter wrap: cyc=0x00010, timestamp 0xFFFF0 gives latency 32.
    for (int k = 0; k < 100 && tb_cyc != 20'h00010; k++) begin @(posedge clk); #1; end
    drive_req(mk(3'd2, 3'd3, 20'hFFFF0, 32'h400));
    wait_ack(8, got, nw);
    chk("t6_acked", {63'd0, got}, 64'd1);
    chk("t6_ack_delay", 64'(nw), 64'd1);
    chk("t6_lat_sum", {32'd0, lat_sum}, 64'd32);
    chk("t6_lat_max", {44'd0, lat_max}, 64'd32);
    check_stats("t6");
    pop_one("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
